// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: ALU op, flag, datapath mux select, FSM state types and RV32I opcode constants
package multicycle_controller_pkg;
  typedef enum logic [1:0] {DEF_ADD, DEF_SUB, TYPE_R, TYPE_I} aluOp_t;
  typedef enum logic {LOW, HIGH} flag_t;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1} srcA_t;
  typedef enum logic [1:0] {SRCB_RS2, SRCB_FOUR, SRCB_IMM} srcB_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP
  } ctrl_state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/multicycle_controller_branch.sv
// branch_cond_unit: (funct3, zero) -> taken for BEQ/BNE, error for any other funct3
module branch_cond_unit (
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  output logic       o_taken,
  output logic       o_error
);
  assign o_error = i_funct3[2:1] != 2'b00;
  assign o_taken = !o_error && (i_zero ^ i_funct3[0]);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM (in: opcode/funct3/zero/aluError/readies; out: datapath strobes, aluOp, trap, state)
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       aluError,
  input  logic       imemReady,
  input  logic       dmemReady,
  output logic       imemReq,
  output logic       dmemRead,
  output logic       dmemWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       regWrite,
  output logic       wbSel,
  output logic       trap,
  output logic [3:0] state
);
  ctrl_state_t r_state, w_next;
  logic w_taken, w_br_err;
  branch_cond_unit u_branch (
    .i_funct3(funct3),
    .i_zero  (zero),
    .o_taken (w_taken),
    .o_error (w_br_err)
  );
  always_ff @(posedge clk) r_state <= rst ? FETCH : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:          w_next = imemReady ? DECODE : FETCH;
      DECODE:         w_next = opcode == OP_R ? EXEC_R :
                               opcode == OP_I ? EXEC_I :
                               (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
                               opcode == OP_BRANCH ? BRANCH : TRAP;
      EXEC_R, EXEC_I: w_next = aluError == HIGH ? TRAP : ALU_WB;
      ALU_WB, MEM_WB: w_next = FETCH;
      MEM_ADDR:       w_next = opcode == OP_LOAD ? MEM_RD : MEM_WR;
      MEM_RD:         w_next = dmemReady ? MEM_WB : MEM_RD;
      MEM_WR:         w_next = dmemReady ? FETCH : MEM_WR;
      BRANCH:         w_next = w_br_err ? TRAP : FETCH;
      default:        w_next = TRAP;
    endcase
  end
  always_comb begin
    imemReq   = 1'b0;
    dmemRead  = 1'b0;
    dmemWrite = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = 1'b0;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_FOUR;
    aluOp     = DEF_ADD;
    regWrite  = 1'b0;
    wbSel     = 1'b0;
    trap      = LOW;
    if (!rst) begin
      case (r_state)
        FETCH: begin
          imemReq = 1'b1;
          irWrite = imemReady;
          pcWrite = imemReady;
        end
        DECODE: begin
          aluSrcA = SRCA_OLDPC;
          aluSrcB = SRCB_IMM;
        end
        EXEC_R: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_RS2;
          aluOp   = TYPE_R;
        end
        EXEC_I: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_IMM;
          aluOp   = TYPE_I;
        end
        ALU_WB: regWrite = 1'b1;
        MEM_ADDR: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_IMM;
        end
        MEM_RD: dmemRead = 1'b1;
        MEM_WB: begin
          regWrite = 1'b1;
          wbSel    = 1'b1;
        end
        MEM_WR: dmemWrite = 1'b1;
        BRANCH: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_RS2;
          aluOp   = DEF_SUB;
          pcSrc   = 1'b1;
          pcWrite = w_taken;
        end
        TRAP:    trap = HIGH;
        default: trap = HIGH;
      endcase
    end
  end
  assign state = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven, hand-written and random instruction sequences checked against a per-instruction cycle model
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, aluError = 1'b0, imemReady = 1'b0, dmemReady = 1'b0;
  logic imemReq, dmemRead, dmemWrite, irWrite, pcWrite, pcSrc, regWrite, wbSel, trap;
  logic [1:0] aluSrcA, aluSrcB, aluOp;
  logic [3:0] state;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic imem, drd, dwr, ir, pcw, pcs;
    logic [1:0] sa, sb, op;
    logic rw, wb, tr;
    logic [3:0] st;
  } exp_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic z, ae;
    int wi, wd;
    logic exp_trap;
  } vec_t;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .aluError(aluError),
    .imemReady(imemReady), .dmemReady(dmemReady), .imemReq(imemReq), .dmemRead(dmemRead),
    .dmemWrite(dmemWrite), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .regWrite(regWrite), .wbSel(wbSel),
    .trap(trap), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e    = '0;
    e.sa = SRCA_PC;
    e.sb = SRCB_FOUR;
    e.op = DEF_ADD;
    e.st = st;
    return e;
  endfunction
  task automatic cyc(input logic ir, input logic dr, input exp_t e, input string nm, input bit nost = 0);
    exp_t act;
    imemReady = ir;
    dmemReady = dr;
    #1;
    act = {imemReq, dmemRead, dmemWrite, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB, aluOp,
           regWrite, wbSel, trap, state};
    checks++;
    if (nost ? act[18:4] !== e[18:4] : act !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic ae,
                          input int wi, input int wd, output bit trapped);
    exp_t e;
    bit r, ld;
    opcode = op; funct3 = f3; zero = z; aluError = ae; trapped = 0;
    repeat (wi) begin
      e = mk(FETCH); e.imem = 1;
      cyc(0, rb(), e, "fetch_wait");
    end
    e = mk(FETCH); e.imem = 1; e.ir = 1; e.pcw = 1;
    cyc(1, rb(), e, "fetch");
    e = mk(DECODE); e.sa = SRCA_OLDPC; e.sb = SRCB_IMM;
    cyc(rb(), rb(), e, "decode");
    if (op == OP_R || op == OP_I) begin
      r = op == OP_R;
      e = mk(r ? EXEC_R : EXEC_I); e.sa = SRCA_RS1;
      e.sb = r ? SRCB_RS2 : SRCB_IMM; e.op = r ? TYPE_R : TYPE_I;
      cyc(rb(), rb(), e, "exec");
      if (ae) trapped = 1;
      else begin
        e = mk(ALU_WB); e.rw = 1;
        cyc(rb(), rb(), e, "alu_wb");
      end
    end else if (op == OP_LOAD || op == OP_STORE) begin
      ld = op == OP_LOAD;
      e = mk(MEM_ADDR); e.sa = SRCA_RS1; e.sb = SRCB_IMM;
      cyc(rb(), rb(), e, "mem_addr");
      e = mk(ld ? MEM_RD : MEM_WR); e.drd = ld; e.dwr = !ld;
      repeat (wd) cyc(rb(), 0, e, "mem_wait");
      cyc(rb(), 1, e, "mem_done");
      if (ld) begin
        e = mk(MEM_WB); e.rw = 1; e.wb = 1;
        cyc(rb(), rb(), e, "mem_wb");
      end
    end else if (op == OP_BRANCH) begin
      e = mk(BRANCH); e.sa = SRCA_RS1; e.sb = SRCB_RS2; e.op = DEF_SUB; e.pcs = 1;
      e.pcw = f3 == 3'd0 ? z : f3 == 3'd1 ? !z : 1'b0;
      trapped = f3 > 3'd1;
      cyc(rb(), rb(), e, "branch");
    end else trapped = 1;
  endtask
  task automatic trap_and_reset(input int n);
    exp_t e;
    repeat (n) begin
      e = mk(TRAP); e.tr = 1;
      cyc(rb(), rb(), e, "trap_hold");
    end
    rst = 1;
    cyc(rb(), rb(), mk(TRAP), "trap_rst");
    rst = 0;
  endtask
  initial begin
    vec_t tbl[$];
    exp_t e;
    bit trapped;
    logic [6:0] ops [6];
    tbl = '{
      '{OP_R,      3'd0, 0, 0, 3, 0, 0},
      '{OP_I,      3'd0, 0, 0, 0, 0, 0},
      '{OP_I,      3'd2, 1, 1, 1, 0, 1},
      '{OP_R,      3'd0, 0, 1, 0, 0, 1},
      '{OP_LOAD,   3'd2, 0, 1, 0, 2, 0},
      '{OP_LOAD,   3'd2, 1, 0, 2, 0, 0},
      '{OP_STORE,  3'd2, 0, 1, 1, 0, 0},
      '{OP_STORE,  3'd2, 0, 0, 0, 3, 0},
      '{OP_BRANCH, 3'd0, 1, 1, 0, 0, 0},
      '{OP_BRANCH, 3'd0, 0, 0, 0, 0, 0},
      '{OP_BRANCH, 3'd1, 1, 0, 1, 0, 0},
      '{OP_BRANCH, 3'd1, 0, 1, 0, 0, 0},
      '{OP_BRANCH, 3'd4, 1, 0, 0, 0, 1},
      '{7'h7f,     3'd0, 0, 0, 2, 0, 1}
    };
    cyc(1, 1, mk(FETCH), "rst_cycle1", 1);
    cyc(1, 1, mk(FETCH), "rst_cycle2");
    rst = 0;
    e = mk(FETCH); e.imem = 1;
    cyc(0, 0, e, "post_rst");
    foreach (tbl[i]) begin
      do_instr(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].ae, tbl[i].wi, tbl[i].wd, trapped);
      #1;
      checks++;
      if (trap !== tbl[i].exp_trap) begin
        errors++;
        $display("FAIL vec%0d_trap act=%b exp=%b", i, trap, tbl[i].exp_trap);
      end
      if (trapped) trap_and_reset(10);
    end
    opcode = OP_STORE;
    e = mk(FETCH); e.imem = 1; e.ir = 1; e.pcw = 1;
    cyc(1, 0, e, "abort_fetch");
    e = mk(DECODE); e.sa = SRCA_OLDPC; e.sb = SRCB_IMM;
    cyc(0, 0, e, "abort_decode");
    e = mk(MEM_ADDR); e.sa = SRCA_RS1; e.sb = SRCB_IMM;
    cyc(0, 0, e, "abort_addr");
    e = mk(MEM_WR); e.dwr = 1;
    cyc(0, 0, e, "abort_memwr");
    rst = 1;
    cyc(1, 1, mk(MEM_WR), "abort_rst");
    rst = 0;
    e = mk(FETCH); e.imem = 1;
    cyc(0, 1, e, "abort_next");
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, 7'h00};
    for (int k = 0; k < 120; k++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 5)];
      if (op == 7'h00) op = 7'($urandom);
      do_instr(op, 3'($urandom_range(0, 7) > 5 ? $urandom_range(2, 7) : $urandom_range(0, 1)),
               rb(), $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3), trapped);
      if (trapped) trap_and_reset(2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
